// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one SRAM-like port between fetch and load/store, one transaction in flight
module mem_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MAX_DATA_RUN = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inst_req,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic              inst_addr_ok,
    output logic              inst_data_ok,
    output logic [DATA_W-1:0] inst_rdata,
    input  logic              data_req,
    input  logic              data_wr,
    input  logic [1:0]        data_size,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic              data_addr_ok,
    output logic              data_data_ok,
    output logic [DATA_W-1:0] data_rdata,
    input  logic              flush,
    output logic              req,
    output logic              wr,
    output logic [1:0]        size,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] wdata,
    input  logic              addr_ok,
    input  logic              data_ok,
    input  logic [DATA_W-1:0] rdata,
    output logic              stall_from_if,
    output logic              stall_from_mem
);
    localparam int CW = $clog2(MAX_DATA_RUN + 1);

    typedef enum logic [2:0] {IDLE, ADDR_I, ADDR_D, WAIT_I, WAIT_D} state_t;

    state_t              r_state, w_next;
    logic                r_wr;
    logic [1:0]          r_size;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_discard;
    logic [CW-1:0]       r_run_cnt;
    logic                w_idle, w_inst_side, w_data_side, w_done_i, w_done_d;
    logic                w_arb, w_grant_d, w_grant_i;

    assign w_idle      = r_state == IDLE;
    assign w_inst_side = (r_state == ADDR_I) || (r_state == WAIT_I);
    assign w_data_side = (r_state == ADDR_D) || (r_state == WAIT_D);
    assign w_done_i    = (r_state == WAIT_I) && data_ok;
    assign w_done_d    = (r_state == WAIT_D) && data_ok;
    assign w_arb       = w_idle || w_done_i || w_done_d;
    assign w_grant_d   = w_arb && data_req && (!inst_req || r_run_cnt != CW'(MAX_DATA_RUN));
    assign w_grant_i   = w_arb && inst_req && !w_grant_d;

    // state register; reset abandons any transaction in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // next state: re-arbitrate when idle or as a response completes, else advance addr -> wait
    always_comb begin
        w_next = r_state;
        if (w_arb)
            w_next = w_grant_d ? ADDR_D : w_grant_i ? ADDR_I : IDLE;
        else if (addr_ok)
            w_next = (r_state == ADDR_I) ? WAIT_I : (r_state == ADDR_D) ? WAIT_D : r_state;
    end

    // latch the winner's request, track the data run length and flushed fetches
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr      <= 1'b0;
            r_size    <= '0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_run_cnt <= '0;
            r_discard <= 1'b0;
        end else begin
            if (w_grant_d) begin
                r_wr      <= data_wr;
                r_size    <= data_size;
                r_addr    <= data_addr;
                r_wdata   <= data_wdata;
                r_run_cnt <= !inst_req ? '0 :
                             (r_run_cnt == CW'(MAX_DATA_RUN)) ? r_run_cnt : r_run_cnt + CW'(1);
            end else if (w_grant_i) begin
                r_wr      <= 1'b0;
                r_size    <= 2'd2;
                r_addr    <= inst_addr;
                r_wdata   <= '0;
                r_run_cnt <= '0;
            end
            if (w_done_i)
                r_discard <= 1'b0;
            else if (flush && w_inst_side)
                r_discard <= 1'b1;
        end
    end

    assign req            = (r_state == ADDR_I) || (r_state == ADDR_D);
    assign wr             = !w_idle && r_wr;
    assign size           = w_idle ? '0 : r_size;
    assign addr           = w_idle ? '0 : r_addr;
    assign wdata          = w_idle ? '0 : r_wdata;
    assign inst_addr_ok   = (r_state == ADDR_I) && addr_ok && !r_discard;
    assign inst_data_ok   = w_done_i && !r_discard && !flush;
    assign inst_rdata     = inst_data_ok ? rdata : '0;
    assign data_addr_ok   = (r_state == ADDR_D) && addr_ok;
    assign data_data_ok   = w_done_d;
    assign data_rdata     = w_done_d ? rdata : '0;
    assign stall_from_if  = !rst && (inst_req || (w_inst_side && !r_discard)) && !inst_data_ok;
    assign stall_from_mem = !rst && (data_req || w_data_side) && !data_data_ok;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: vector table, hand sequences and randomized model check of mem_arbiter
module tb_mem_arbiter;
    localparam int MR = 4;
    localparam logic [31:0] IA = 32'hBFC00000;
    localparam logic [31:0] DA = 32'h80001000;
    localparam logic [31:0] WD = 32'hDEADBEEF;
    localparam logic [31:0] RD = 32'h3C1D0001;

    typedef logic [137:0] ov_t;
    // inputs ir dr ao dk fl | st (0 idle, 1 inst, 2 data) | rq ia id da dd si sm
    typedef struct packed {
        bit ir, dr, ao, dk, fl;
        bit [1:0] st;
        bit rq, ia, id, da, dd, si, sm;
    } row_t;

    logic        clk = 0, rst = 1;
    logic        inst_req = 0, data_req = 0, data_wr = 0, flush = 0, addr_ok = 0, data_ok = 0;
    logic [31:0] inst_addr = 0, data_addr = 0, data_wdata = 0, rdata = 0;
    logic [1:0]  data_size = 0;
    logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok, req, wr;
    logic        stall_from_if, stall_from_mem;
    logic [31:0] inst_rdata, data_rdata, addr, wdata;
    logic [1:0]  size;

    int   n_cmp = 0, n_bad = 0;
    row_t tbl[$];

    bit          m_busy, m_who, m_sent, m_disc, acc_i, acc_d;
    int          m_run;
    logic        m_wr;
    logic [1:0]  m_size;
    logic [31:0] m_addr, m_wdata;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_DATA_RUN(MR)) dut (
        .clk(clk), .rst(rst),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .data_rdata(data_rdata), .flush(flush),
        .req(req), .wr(wr), .size(size), .addr(addr), .wdata(wdata),
        .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata),
        .stall_from_if(stall_from_if), .stall_from_mem(stall_from_mem)
    );

    function automatic ov_t outs();
        return {req, wr, size, addr, wdata, inst_addr_ok, inst_data_ok, inst_rdata,
                data_addr_ok, data_data_ok, data_rdata, stall_from_if, stall_from_mem};
    endfunction

    function automatic ov_t mk(bit rq, bit w, logic [1:0] sz, logic [31:0] a, logic [31:0] wd,
                               bit ia, bit id, logic [31:0] ir, bit da, bit dd,
                               logic [31:0] dr, bit si, bit sm);
        return {rq, w, sz, a, wd, ia, id, ir, da, dd, dr, si, sm};
    endfunction

    task automatic check(string name, ov_t act, ov_t exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %h want %h", name, $time, act, exp);
        end
    endtask

    task automatic add(row_t r);
        tbl.push_back(r);
    endtask

    // outputs must stay zero during reset even with requests pending
    task automatic do_reset();
        rst = 1; inst_req = 1; data_req = 1; addr_ok = 1; data_ok = 1; flush = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset", outs(), '0);
        inst_req = 0; data_req = 0; addr_ok = 0; data_ok = 0;
        @(posedge clk); #1 rst = 0;
    endtask

    initial begin
        bit done, ia, id, da, dd, si, sm, fp;
        logic [9:0] gexp;
        int g;
        // single inst read, data_ok in IDLE ignored
        add(14'b10000_00_0000010); tbl.delete(tbl.size() - 1);
        add(14'b00000_00_0000000); add(14'b10000_00_0000010); add(14'b10000_01_1000010);
        add(14'b10100_01_1100010); add(14'b00000_01_0000010); add(14'b00000_01_0000010);
        add(14'b00010_01_0010000); add(14'b00000_00_0000000); add(14'b00110_00_0000000);
        // store and fetch together: data first, inst granted back-to-back
        add(14'b11000_00_0000011); add(14'b11100_10_1001011); add(14'b10010_10_0000110);
        add(14'b10100_01_1100010); add(14'b00010_01_0010000); add(14'b00000_00_0000000);
        // flush in WAIT_I, then normal fetch
        add(14'b10000_00_0000010); add(14'b10100_01_1100010); add(14'b00001_01_0000010);
        add(14'b00000_01_0000000); add(14'b00010_01_0000000); add(14'b10000_00_0000010);
        add(14'b10100_01_1100010); add(14'b00010_01_0010000);
        // flush together with the WAIT_I response
        add(14'b10000_00_0000010); add(14'b10100_01_1100010); add(14'b00011_01_0000010);
        add(14'b10000_00_0000010); add(14'b10100_01_1100010); add(14'b00010_01_0010000);
        // flush in ADDR_I: address accept hidden, request not retracted
        add(14'b10000_00_0000010); add(14'b10001_01_1000010); add(14'b00100_01_1000000);
        add(14'b00010_01_0000000); add(14'b00000_00_0000000);
        // flush has no effect on the data side
        add(14'b01001_00_0000001); add(14'b01101_10_1001001); add(14'b00011_10_0000100);
        add(14'b00000_00_0000000);

        do_reset();
        inst_addr = IA; data_addr = DA; data_wdata = WD; data_size = 2; data_wr = 1; rdata = RD;
        foreach (tbl[i]) begin
            inst_req = tbl[i].ir; data_req = tbl[i].dr; addr_ok = tbl[i].ao;
            data_ok = tbl[i].dk; flush = tbl[i].fl;
            @(negedge clk);
            check($sformatf("vec%0d", i), outs(),
                  mk(tbl[i].rq, tbl[i].st == 2, tbl[i].st != 0 ? 2'd2 : 2'd0,
                     tbl[i].st == 1 ? IA : tbl[i].st == 2 ? DA : 32'h0,
                     tbl[i].st == 2 ? WD : 32'h0, tbl[i].ia, tbl[i].id, tbl[i].id ? RD : 32'h0,
                     tbl[i].da, tbl[i].dd, tbl[i].dd ? RD : 32'h0, tbl[i].si, tbl[i].sm));
            @(posedge clk); #1;
        end

        // run limit: both requesters held, grant order D D D D I repeating
        do_reset();
        inst_req = 1; data_req = 1; addr_ok = 1; data_ok = 1;
        gexp = 10'b1111011110;
        g = 0;
        for (int c = 0; c < 100 && g < 10; c++) begin
            @(negedge clk);
            if (req) begin
                check($sformatf("grant%0d_wr", g), ov_t'(wr), ov_t'(gexp[9-g]));
                g++;
            end
            @(posedge clk); #1;
        end
        if (g < 10) begin
            n_cmp++; n_bad++;
            $display("FAIL grant_timeout: got %0d grants want 10", g);
        end
        inst_req = 0; data_req = 0; addr_ok = 0; data_ok = 0;

        // reset while in WAIT_D, then a normal load
        do_reset();
        data_req = 1; data_wr = 0; data_addr = 32'h80002000; data_wdata = 0; data_size = 2;
        @(posedge clk); #1 addr_ok = 1;
        @(posedge clk); #1 data_req = 0; addr_ok = 0;
        @(negedge clk);
        check("wait_d", outs(), mk(0, 0, 2, 32'h80002000, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        rst = 1; data_ok = 1; rdata = 32'hCAFEF00D;
        #1 check("mid_reset", outs(), '0);
        @(posedge clk); #1 rst = 0;
        @(negedge clk);
        check("post_reset", outs(), '0);
        @(posedge clk); #1 data_ok = 0; data_req = 1;
        @(posedge clk); #1 addr_ok = 1;
        @(posedge clk); #1 data_req = 0; addr_ok = 0; data_ok = 1;
        @(negedge clk);
        check("load_after_reset", outs(),
              mk(0, 0, 2, 32'h80002000, 0, 0, 0, 0, 0, 1, 32'hCAFEF00D, 0, 0));
        @(posedge clk); #1 data_ok = 0;

        // randomized traffic against a transaction-level model
        do_reset();
        m_busy = 0; m_who = 0; m_sent = 0; m_disc = 0; m_run = 0; acc_i = 0; acc_d = 0;
        m_wr = 0; m_size = 0; m_addr = 0; m_wdata = 0;
        for (int c = 0; c < 3000; c++) begin
            fp = flush;
            if (acc_i || !inst_req || fp) begin
                inst_req = $urandom_range(0, 3) != 0; inst_addr = $urandom;
            end
            if (acc_d || !data_req) begin
                data_req = $urandom_range(0, 2) == 0; data_wr = 1'($urandom_range(0, 1));
                data_size = 2'($urandom_range(0, 2)); data_addr = $urandom; data_wdata = $urandom;
            end
            addr_ok = 1'($urandom_range(0, 1)); data_ok = 1'($urandom_range(0, 1));
            flush = $urandom_range(0, 9) == 0; rdata = $urandom;
            @(negedge clk);
            done = m_busy && m_sent && data_ok;
            ia = m_busy && !m_who && !m_sent && addr_ok && !m_disc;
            da = m_busy && m_who && !m_sent && addr_ok;
            id = done && !m_who && !m_disc && !flush;
            dd = done && m_who;
            si = (inst_req || (m_busy && !m_who && !m_disc)) && !id;
            sm = (data_req || (m_busy && m_who)) && !dd;
            check("rand", outs(),
                  mk(m_busy && !m_sent, m_busy && m_wr, m_busy ? m_size : 2'd0,
                     m_busy ? m_addr : 32'h0, m_busy ? m_wdata : 32'h0, ia, id,
                     id ? rdata : 32'h0, da, dd, dd ? rdata : 32'h0, si, sm));
            if (m_busy && !m_who && done) m_disc = 0;
            else if (m_busy && !m_who && flush) m_disc = 1;
            if (m_busy && !m_sent && addr_ok) m_sent = 1;
            if (!m_busy || done) begin
                m_sent = 0;
                if (data_req && (!inst_req || m_run < MR)) begin
                    m_busy = 1; m_who = 1; m_wr = data_wr; m_size = data_size;
                    m_addr = data_addr; m_wdata = data_wdata;
                    m_run = inst_req ? (m_run < MR ? m_run + 1 : MR) : 0;
                end else if (inst_req) begin
                    m_busy = 1; m_who = 0; m_wr = 0; m_size = 2; m_addr = inst_addr; m_wdata = 0;
                    m_run = 0;
                end else begin
                    m_busy = 0;
                end
            end
            acc_i = ia; acc_d = da;
            @(posedge clk); #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
